// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: arbiter FSM states and the transaction command record
// shared by the arbiter and the PHY-side command register.
package hyperbus_pkg;

    // Field widths of the command record; the arbiter and PHY parameters must match.
    localparam int unsigned HB_NR_CS      = 2;
    localparam int unsigned HB_BURST_W    = 12;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DATA
    } arb_state_e;

    typedef struct packed {
        logic [31:0]           address;
        logic [HB_NR_CS-1:0]   cs;
        logic                  write;
        logic [HB_BURST_W-1:0] burst;
        logic                  address_space;
    } hyper_trans_t;

endpackage

// File: rtl/hyperbus_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping modulo NR_PORTS, as one-hot grant plus binary index.
module hyperbus_rr_arbiter #(
    parameter int unsigned NR_PORTS = 2
) (
    input  logic [NR_PORTS-1:0]         i_req,
    input  logic [$clog2(NR_PORTS)-1:0] i_ptr,
    output logic [NR_PORTS-1:0]         o_gnt,
    output logic [$clog2(NR_PORTS)-1:0] o_idx,
    output logic                        o_valid
);

    localparam int unsigned IDX_W = $clog2(NR_PORTS);

    logic [IDX_W-1:0] w_cand;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = '0;
        for (int unsigned k = 0; k < NR_PORTS; k++) begin
            w_cand = IDX_W'((32'(i_ptr) + k) % NR_PORTS);
            if (!o_valid && i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = w_cand;
            end
        end
    end

    assign o_gnt = o_valid ? (NR_PORTS'(1) << o_idx) : '0;

endmodule

// File: rtl/hyperbus_trans_arbiter.sv
// Round-robin arbiter sharing one hyperbus_phy transaction/tx/rx interface
// between NR_PORTS requesters; one latched command per grant, re-arbitrates after the burst.
module hyperbus_trans_arbiter
    import hyperbus_pkg::*;
#(
    parameter int unsigned NR_PORTS    = 2,
    parameter int unsigned BURST_WIDTH = HB_BURST_W,
    parameter int unsigned NR_CS       = HB_NR_CS
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NR_PORTS-1:0]             req_trans_valid_i,
    output logic [NR_PORTS-1:0]             req_trans_ready_o,
    input  logic [NR_PORTS*32-1:0]          req_trans_address_i,
    input  logic [NR_PORTS*NR_CS-1:0]       req_trans_cs_i,
    input  logic [NR_PORTS-1:0]             req_trans_write_i,
    input  logic [NR_PORTS*BURST_WIDTH-1:0] req_trans_burst_i,
    input  logic [NR_PORTS-1:0]             req_trans_address_space_i,
    input  logic [NR_PORTS-1:0]             req_tx_valid_i,
    output logic [NR_PORTS-1:0]             req_tx_ready_o,
    input  logic [NR_PORTS*16-1:0]          req_tx_data_i,
    input  logic [NR_PORTS*2-1:0]           req_tx_strb_i,
    output logic [NR_PORTS-1:0]             req_rx_valid_o,
    input  logic [NR_PORTS-1:0]             req_rx_ready_i,
    output logic [15:0]                     req_rx_data_o,
    output logic                            trans_valid_o,
    input  logic                            trans_ready_i,
    output logic [31:0]                     trans_address_o,
    output logic [NR_CS-1:0]                trans_cs_o,
    output logic                            trans_write_o,
    output logic [BURST_WIDTH-1:0]          trans_burst_o,
    output logic                            trans_address_space_o,
    output logic                            tx_valid_o,
    input  logic                            tx_ready_i,
    output logic [15:0]                     tx_data_o,
    output logic [1:0]                      tx_strb_o,
    input  logic                            rx_valid_i,
    output logic                            rx_ready_o,
    input  logic [15:0]                     rx_data_i,
    output logic [$clog2(NR_PORTS)-1:0]     grant_o,
    output logic                            busy_o,
    output logic                            err_o
);

    localparam int unsigned IDX_W = $clog2(NR_PORTS);

    arb_state_e             r_state;
    hyper_trans_t           r_cmd;
    logic [IDX_W-1:0]       r_grant;
    logic [IDX_W-1:0]       r_ptr;
    logic [BURST_WIDTH-1:0] r_count;
    logic                   r_trans_valid;

    logic [NR_PORTS-1:0]    w_pick_onehot;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_ptr_next;
    logic [BURST_WIDTH-1:0] w_pick_burst;
    logic                   w_pick_illegal;
    logic [NR_PORTS-1:0]    w_grant_onehot;
    logic                   w_beat;

    hyperbus_rr_arbiter #(
        .NR_PORTS(NR_PORTS)
    ) u_rr (
        .i_req  (req_trans_valid_i),
        .i_ptr  (r_ptr),
        .o_gnt  (w_pick_onehot),
        .o_idx  (w_pick_idx),
        .o_valid(w_pick_valid)
    );

    assign w_ptr_next     = (w_pick_idx == IDX_W'(NR_PORTS - 1)) ? '0 : w_pick_idx + IDX_W'(1);
    assign w_pick_burst   = req_trans_burst_i[BURST_WIDTH*w_pick_idx +: BURST_WIDTH];
    // Zero-length bursts are refused in IDLE: acknowledged and flagged, never sent to the PHY.
    assign w_pick_illegal = (r_state == ST_IDLE) && w_pick_valid && (w_pick_burst == '0) && !rst_i;
    assign w_grant_onehot = NR_PORTS'(1) << r_grant;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= ST_IDLE;
            r_cmd         <= '0;
            r_grant       <= '0;
            r_ptr         <= '0;
            r_count       <= '0;
            r_trans_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_ptr <= w_ptr_next;
                        if (!w_pick_illegal) begin
                            r_grant               <= w_pick_idx;
                            r_cmd.address         <= req_trans_address_i[32*w_pick_idx +: 32];
                            r_cmd.cs              <= req_trans_cs_i[NR_CS*w_pick_idx +: NR_CS];
                            r_cmd.write           <= req_trans_write_i[w_pick_idx];
                            r_cmd.burst           <= w_pick_burst;
                            r_cmd.address_space   <= req_trans_address_space_i[w_pick_idx];
                            r_trans_valid         <= 1'b1;
                            r_state               <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (trans_ready_i) begin
                        r_trans_valid <= 1'b0;
                        r_state       <= ST_DATA;
                        // A register write carries exactly one data beat whatever the burst says.
                        r_count       <= (r_cmd.address_space && r_cmd.write) ? BURST_WIDTH'(1)
                                                                             : r_cmd.burst;
                    end
                end
                ST_DATA: begin
                    if (w_beat) begin
                        if (r_count == BURST_WIDTH'(1)) begin
                            r_state <= ST_IDLE;
                        end
                        if (r_count != '0) begin
                            r_count <= r_count - BURST_WIDTH'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        req_trans_ready_o = '0;
        req_tx_ready_o    = '0;
        req_rx_valid_o    = '0;
        tx_valid_o        = 1'b0;
        tx_data_o         = req_tx_data_i[16*r_grant +: 16];
        tx_strb_o         = req_tx_strb_i[2*r_grant +: 2];
        rx_ready_o        = 1'b0;
        w_beat            = 1'b0;
        if (w_pick_illegal) begin
            req_trans_ready_o = w_pick_onehot;
        end
        if (r_state == ST_ISSUE && trans_ready_i && !rst_i) begin
            req_trans_ready_o = w_grant_onehot;
        end
        if (r_state == ST_DATA) begin
            if (r_cmd.write) begin
                tx_valid_o              = req_tx_valid_i[r_grant];
                req_tx_ready_o[r_grant] = tx_ready_i;
                w_beat                  = req_tx_valid_i[r_grant] && tx_ready_i;
            end else begin
                req_rx_valid_o[r_grant] = rx_valid_i;
                rx_ready_o              = req_rx_ready_i[r_grant];
                w_beat                  = rx_valid_i && req_rx_ready_i[r_grant];
            end
        end
    end

    assign req_rx_data_o         = rx_data_i;
    assign trans_valid_o         = r_trans_valid;
    assign trans_address_o       = r_cmd.address;
    assign trans_cs_o            = r_cmd.cs;
    assign trans_write_o         = r_cmd.write;
    assign trans_burst_o         = r_cmd.burst;
    assign trans_address_space_o = r_cmd.address_space;
    assign grant_o               = r_grant;
    assign busy_o                = (r_state != ST_IDLE);
    assign err_o                 = w_pick_illegal;

endmodule

// File: tb/tb_hyperbus_trans_arbiter.sv
// Directed self-checking bench for hyperbus_trans_arbiter (2 ports): read, round-robin,
// gapped write, register write, illegal burst and mid-transaction reset.
module tb_hyperbus_trans_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [1:0]  req_trans_valid_i, req_trans_ready_o;
    logic [63:0] req_trans_address_i;
    logic [3:0]  req_trans_cs_i;
    logic [1:0]  req_trans_write_i;
    logic [23:0] req_trans_burst_i;
    logic [1:0]  req_trans_address_space_i;
    logic [1:0]  req_tx_valid_i, req_tx_ready_o;
    logic [31:0] req_tx_data_i;
    logic [3:0]  req_tx_strb_i;
    logic [1:0]  req_rx_valid_o, req_rx_ready_i;
    logic [15:0] req_rx_data_o;
    logic        trans_valid_o, trans_ready_i;
    logic [31:0] trans_address_o;
    logic [1:0]  trans_cs_o;
    logic        trans_write_o;
    logic [11:0] trans_burst_o;
    logic        trans_address_space_o;
    logic        tx_valid_o, tx_ready_i;
    logic [15:0] tx_data_o;
    logic [1:0]  tx_strb_o;
    logic        rx_valid_i, rx_ready_o;
    logic [15:0] rx_data_i;
    logic [0:0]  grant_o;
    logic        busy_o, err_o;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned rdy0_cnt, err_cnt, rx1_cnt;
    logic [17:0] tx_q[$];

    hyperbus_trans_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_trans_valid_i(req_trans_valid_i), .req_trans_ready_o(req_trans_ready_o),
        .req_trans_address_i(req_trans_address_i), .req_trans_cs_i(req_trans_cs_i),
        .req_trans_write_i(req_trans_write_i), .req_trans_burst_i(req_trans_burst_i),
        .req_trans_address_space_i(req_trans_address_space_i),
        .req_tx_valid_i(req_tx_valid_i), .req_tx_ready_o(req_tx_ready_o),
        .req_tx_data_i(req_tx_data_i), .req_tx_strb_i(req_tx_strb_i),
        .req_rx_valid_o(req_rx_valid_o), .req_rx_ready_i(req_rx_ready_i),
        .req_rx_data_o(req_rx_data_o),
        .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i),
        .trans_address_o(trans_address_o), .trans_cs_o(trans_cs_o),
        .trans_write_o(trans_write_o), .trans_burst_o(trans_burst_o),
        .trans_address_space_o(trans_address_space_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
        .tx_data_o(tx_data_o), .tx_strb_o(tx_strb_o),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .rx_data_i(rx_data_i),
        .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // PHY/requester-side observers, sampled mid-cycle.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (req_trans_ready_o[0]) rdy0_cnt++;
            if (err_o) err_cnt++;
            if (req_rx_valid_o[1]) rx1_cnt++;
            if (tx_valid_o && tx_ready_i) tx_q.push_back({tx_data_o, tx_strb_o});
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        req_trans_valid_i = '0; req_trans_address_i = '0; req_trans_cs_i = '0;
        req_trans_write_i = '0; req_trans_burst_i = '0; req_trans_address_space_i = '0;
        req_tx_valid_i = '0; req_tx_data_i = '0; req_tx_strb_i = '0; req_rx_ready_i = '0;
        trans_ready_i = 1'b0; tx_ready_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_i = 1'b1;
        next_cycle();
        next_cycle();
        rst_i = 1'b0;
        rdy0_cnt = 0; err_cnt = 0; rx1_cnt = 0;
        tx_q.delete();
    endtask

    task automatic set_req(input int p, input logic [31:0] addr, input logic [11:0] burst,
                           input logic wr, input logic sp);
        req_trans_valid_i[p]              = 1'b1;
        req_trans_address_i[32*p +: 32]   = addr;
        req_trans_cs_i[2*p +: 2]          = 2'(p + 1);
        req_trans_burst_i[12*p +: 12]     = burst;
        req_trans_write_i[p]              = wr;
        req_trans_address_space_i[p]      = sp;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (trans_valid_o !== 1'b0) begin failures++; $display("FAIL reset_trans_valid: got %b want 0", trans_valid_o); end
        checks++; if (grant_o !== 1'b0) begin failures++; $display("FAIL reset_grant: got %b want 0", grant_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", err_o); end
        checks++; if ({req_trans_ready_o, req_tx_ready_o, req_rx_valid_o, tx_valid_o, rx_ready_o} !== 8'b0) begin
            failures++; $display("FAIL reset_handshakes: got %b want 0", {req_trans_ready_o, req_tx_ready_o, req_rx_valid_o, tx_valid_o, rx_ready_o});
        end
        next_cycle();
    endtask

    task automatic test_read();
        logic [15:0] exp_d;
        do_reset();
        set_req(0, 32'h100, 12'd4, 1'b0, 1'b0);
        req_rx_ready_i = 2'b11;
        @(negedge clk_i);
        checks++; if (trans_valid_o !== 1'b0) begin failures++; $display("FAIL read_latency: trans_valid got %b want 0 in detect cycle", trans_valid_o); end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({trans_valid_o, trans_address_o, trans_burst_o, trans_write_o, trans_cs_o, busy_o} !== {1'b1, 32'h100, 12'd4, 1'b0, 2'd1, 1'b1}) begin
            failures++; $display("FAIL read_cmd: got v=%b a=%h b=%0d w=%b cs=%0d busy=%b", trans_valid_o, trans_address_o, trans_burst_o, trans_write_o, trans_cs_o, busy_o);
        end
        checks++; if (req_trans_ready_o !== 2'b00) begin failures++; $display("FAIL read_early_ready: got %b want 00", req_trans_ready_o); end
        next_cycle();
        trans_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if (req_trans_ready_o !== 2'b01) begin failures++; $display("FAIL read_accept: got %b want 01", req_trans_ready_o); end
        next_cycle();
        trans_ready_i = 1'b0;
        req_trans_valid_i = 2'b00;
        for (int b = 0; b < 4; b++) begin
            rx_valid_i = 1'b1;
            exp_d = 16'h00A0 + 16'(b);
            rx_data_i = exp_d;
            @(negedge clk_i);
            checks++; if ({req_rx_valid_o, req_rx_data_o, rx_ready_o} !== {2'b01, exp_d, 1'b1}) begin
                failures++; $display("FAIL read_beat%0d: got v=%b d=%h r=%b want v=01 d=%h r=1", b, req_rx_valid_o, req_rx_data_o, rx_ready_o, exp_d);
            end
            next_cycle();
        end
        rx_valid_i = 1'b0;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL read_done_busy: got %b want 0", busy_o); end
        checks++; if (rdy0_cnt !== 1) begin failures++; $display("FAIL read_accept_count: got %0d want 1", rdy0_cnt); end
        checks++; if (rx1_cnt !== 0) begin failures++; $display("FAIL read_port1_rx: got %0d want 0", rx1_cnt); end
        next_cycle();
    endtask

    task automatic test_rr_alternate();
        int   n;
        logic exp_g;
        do_reset();
        set_req(0, 32'h1000, 12'd2, 1'b0, 1'b0);
        set_req(1, 32'h2000, 12'd2, 1'b0, 1'b0);
        trans_ready_i = 1'b1; rx_valid_i = 1'b1; rx_data_i = 16'h5555; req_rx_ready_i = 2'b11;
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk_i);
            if (trans_valid_o && trans_ready_i) begin
                exp_g = n[0];
                checks++; if (grant_o !== exp_g) begin failures++; $display("FAIL rr_grant%0d: got %b want %b", n, grant_o, exp_g); end
                checks++; if (trans_address_o !== (exp_g ? 32'h2000 : 32'h1000)) begin
                    failures++; $display("FAIL rr_addr%0d: got %h", n, trans_address_o);
                end
                n++;
            end
            next_cycle();
        end
        checks++; if (n != 4) begin failures++; $display("FAIL rr_timeout: got %0d grants want 4", n); end
    endtask

    task automatic test_write_gapped();
        logic [15:0] wdata [3];
        logic [3:0]  pat;
        int          d;
        wdata[0] = 16'h1111; wdata[1] = 16'h2222; wdata[2] = 16'h3333;
        pat = 4'b1101;
        do_reset();
        set_req(1, 32'h200, 12'd3, 1'b1, 1'b0);
        req_tx_data_i = {16'h1111, 16'hDEAD};
        req_tx_strb_i = {2'b10, 2'b01};
        req_tx_valid_i = 2'b01;
        tx_ready_i = 1'b1;
        next_cycle();
        trans_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if ({req_trans_ready_o, trans_write_o, grant_o} !== {2'b10, 1'b1, 1'b1}) begin
            failures++; $display("FAIL wr_accept: got rdy=%b w=%b g=%b want 10 1 1", req_trans_ready_o, trans_write_o, grant_o);
        end
        next_cycle();
        trans_ready_i = 1'b0;
        req_trans_valid_i = 2'b00;
        d = 0;
        for (int k = 0; k < 4; k++) begin
            req_tx_valid_i[1] = pat[k];
            req_tx_data_i[31:16] = wdata[d];
            @(negedge clk_i);
            checks++; if ({busy_o, req_tx_ready_o} !== 3'b110) begin
                failures++; $display("FAIL wr_hold%0d: got busy=%b txr=%b want 1 10", k, busy_o, req_tx_ready_o);
            end
            if (pat[k]) d++;
            next_cycle();
        end
        req_tx_valid_i = 2'b00;
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL wr_done_busy: got %b want 0", busy_o); end
        checks++; if (tx_q.size() != 3) begin failures++; $display("FAIL wr_beats: got %0d want 3", tx_q.size()); end
        for (int i = 0; i < 3 && i < tx_q.size(); i++) begin
            checks++; if (tx_q[i] !== {wdata[i], 2'b10}) begin
                failures++; $display("FAIL wr_data%0d: got %h want %h", i, tx_q[i], {wdata[i], 2'b10});
            end
        end
        next_cycle();
    endtask

    task automatic test_reg_write();
        do_reset();
        set_req(0, 32'h0000_0800, 12'd8, 1'b1, 1'b1);
        req_tx_valid_i = 2'b01;
        req_tx_data_i = {16'h0000, 16'hBEEF};
        req_tx_strb_i = 4'b0011;
        tx_ready_i = 1'b1;
        next_cycle();
        trans_ready_i = 1'b1;
        @(negedge clk_i);
        checks++; if ({trans_burst_o, trans_address_space_o} !== {12'd8, 1'b1}) begin
            failures++; $display("FAIL reg_cmd: got b=%0d sp=%b want 8 1", trans_burst_o, trans_address_space_o);
        end
        next_cycle();
        trans_ready_i = 1'b0;
        req_trans_valid_i = 2'b00;
        next_cycle();
        @(negedge clk_i);
        checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reg_done_busy: got %b want 0", busy_o); end
        next_cycle();
        next_cycle();
        checks++; if (tx_q.size() != 1) begin failures++; $display("FAIL reg_beats: got %0d want 1", tx_q.size()); end
        if (tx_q.size() > 0) begin
            checks++; if (tx_q[0] !== {16'hBEEF, 2'b11}) begin failures++; $display("FAIL reg_data: got %h want %h", tx_q[0], {16'hBEEF, 2'b11}); end
        end
    endtask

    task automatic test_illegal();
        do_reset();
        set_req(0, 32'h300, 12'd0, 1'b0, 1'b0);
        @(negedge clk_i);
        checks++; if ({err_o, req_trans_ready_o, trans_valid_o} !== {1'b1, 2'b01, 1'b0}) begin
            failures++; $display("FAIL ill_pulse: got err=%b rdy=%b tv=%b want 1 01 0", err_o, req_trans_ready_o, trans_valid_o);
        end
        next_cycle();
        req_trans_valid_i = 2'b00;
        set_req(1, 32'h400, 12'd1, 1'b0, 1'b0);
        @(negedge clk_i);
        checks++; if ({err_o, trans_valid_o, busy_o} !== 3'b000) begin
            failures++; $display("FAIL ill_after: got err=%b tv=%b busy=%b want 000", err_o, trans_valid_o, busy_o);
        end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({trans_valid_o, grant_o, trans_address_o} !== {1'b1, 1'b1, 32'h400}) begin
            failures++; $display("FAIL ill_next_grant: got tv=%b g=%b a=%h want 1 1 400", trans_valid_o, grant_o, trans_address_o);
        end
        checks++; if (err_cnt !== 1) begin failures++; $display("FAIL ill_err_count: got %0d want 1", err_cnt); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 32'h500, 12'd4, 1'b0, 1'b0);
        req_rx_ready_i = 2'b11;
        next_cycle();
        trans_ready_i = 1'b1;
        next_cycle();
        trans_ready_i = 1'b0;
        req_trans_valid_i = 2'b00;
        rx_valid_i = 1'b1;
        rx_data_i = 16'h1234;
        @(negedge clk_i);
        checks++; if ({busy_o, req_rx_valid_o} !== 3'b101) begin
            failures++; $display("FAIL rst_mid_data: got busy=%b rxv=%b want 1 01", busy_o, req_rx_valid_o);
        end
        next_cycle();
        rst_i = 1'b1;
        next_cycle();
        rst_i = 1'b0;
        set_req(0, 32'h600, 12'd1, 1'b0, 1'b0);
        set_req(1, 32'h700, 12'd1, 1'b0, 1'b0);
        @(negedge clk_i);
        checks++; if ({busy_o, trans_valid_o, req_rx_valid_o, rx_ready_o, tx_valid_o, err_o, req_trans_ready_o, grant_o} !== 10'b0) begin
            failures++; $display("FAIL rst_mid_outputs: got busy=%b tv=%b rxv=%b rxr=%b txv=%b err=%b rdy=%b g=%b want all 0",
                                 busy_o, trans_valid_o, req_rx_valid_o, rx_ready_o, tx_valid_o, err_o, req_trans_ready_o, grant_o);
        end
        next_cycle();
        @(negedge clk_i);
        checks++; if ({trans_valid_o, grant_o, trans_address_o} !== {1'b1, 1'b0, 32'h600}) begin
            failures++; $display("FAIL rst_mid_ptr: got tv=%b g=%b a=%h want 1 0 600", trans_valid_o, grant_o, trans_address_o);
        end
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_rr_alternate();
        test_write_gapped();
        test_reg_write();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hyperbus_trans_arbiter.md
Name: hyperbus_trans_arbiter

Overview:
Round-robin arbiter that shares one hyperbus_phy transaction/tx/rx interface between NR_PORTS requesters (e.g. AXI slave, config master, debug).
- Grants one requester per transaction and latches its command.
- Routes that requester's tx/rx beats to and from the PHY until the burst completes, then re-arbitrates.
- Sits directly in front of hyperbus_phy.

Parameters:
NR_PORTS, 2, number of requesters (2..8)
BURST_WIDTH, 12, burst length field width, matches PHY
NR_CS, 2, chip-select width, matches PHY

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, synchronous, active-high
req_trans_valid_i  in  NR_PORTS  per-port transaction request
req_trans_ready_o  out  NR_PORTS  one-cycle accept pulse per port
req_trans_address_i  in  NR_PORTS*32  per-port address, port p at [32p+:32]
req_trans_cs_i  in  NR_PORTS*NR_CS  per-port chip select
req_trans_write_i  in  NR_PORTS  per-port write flag
req_trans_burst_i  in  NR_PORTS*BURST_WIDTH  per-port burst length in 16-bit beats
req_trans_address_space_i  in  NR_PORTS  per-port register-space flag
req_tx_valid_i / req_tx_ready_o  in/out  NR_PORTS  per-port write-data handshake
req_tx_data_i  in  NR_PORTS*16  per-port write data
req_tx_strb_i  in  NR_PORTS*2  per-port write strobes
req_rx_valid_o / req_rx_ready_i  out/in  NR_PORTS  per-port read-data handshake
req_rx_data_o  out  16  read data, broadcast to all ports
trans_valid_o / trans_ready_i  out/in  1  PHY transaction handshake
trans_address_o, trans_cs_o, trans_write_o, trans_burst_o, trans_address_space_o  out  32/NR_CS/1/BURST_WIDTH/1  PHY command, from latched copy
tx_valid_o / tx_ready_i, tx_data_o 16, tx_strb_o 2  PHY write-data channel
rx_valid_i / rx_ready_o, rx_data_i 16  PHY read-data channel
grant_o  out  $clog2(NR_PORTS)  owning port, valid while busy_o
busy_o  out  1  transaction in flight
err_o  out  1  one-cycle pulse on an illegal (burst==0) request

Behaviour:
- Reset outputs: all valid/ready outputs 0, busy_o=0, grant_o=0, err_o=0, rr pointer=0, state IDLE.
- States: IDLE, ISSUE, DATA.
- IDLE:
  - Pick the first requesting port at or after the rr pointer, wrapping modulo NR_PORTS.
  - Latch that port's address/cs/write/burst/space and the port index.
  - Set rr pointer = winner+1 (wrap).
  - Go to ISSUE. trans_valid_o rises the cycle after the request is seen (1-cycle latency).
- Illegal request (burst==0) in IDLE:
  - Not forwarded to the PHY.
  - req_trans_ready_o[p] and err_o pulse in that same cycle.
  - rr pointer still advances; state stays IDLE.
- ISSUE:
  - Hold trans_valid_o=1 with stable command until trans_ready_i=1.
  - That cycle: drop trans_valid_o, pulse req_trans_ready_o[grant]=1, go to DATA.
  - Load beat counter = latched burst. If space=1 and write=1, load 1 instead (the PHY consumes exactly one register beat).
- DATA, write:
  - tx_valid_o=req_tx_valid_i[grant] and req_tx_ready_o[grant]=tx_ready_i.
  - tx_data_o/tx_strb_o muxed from the grant port.
  - Decrement the counter on each tx_valid&tx_ready.
- DATA, read:
  - req_rx_valid_o[grant]=rx_valid_i and rx_ready_o=req_rx_ready_i[grant].
  - Decrement the counter on each rx_valid&rx_ready.
- Non-granted ports always see tx_ready=0 and rx_valid=0.
- Last beat: a handshake with counter==1 goes to IDLE next cycle. busy_o falls and a new grant may issue immediately; the PHY's trans_ready handshake provides backpressure during its t_RWR.
- busy_o=1 in ISSUE and DATA.
- A requester dropping req_trans_valid_i after grant does not abort the transaction; the latched command is used.
- Reset mid-transaction returns to IDLE with all outputs at reset values. The PHY must be reset concurrently.
- The counter is BURST_WIDTH bits and never underflows; the DATA exit is evaluated before the decrement.

Decomposition:
- Shared package hyperbus_pkg holds the arbiter state enum (IDLE, ISSUE, DATA) and a hyper_trans_t struct {address, cs, write, burst, address_space}, reused by the PHY-side command register.
- One sub-module: hyperbus_rr_arbiter. Combinational round-robin pick from a request vector and pointer, outputting a one-hot grant, an index and a valid flag.

Test Plan:
- Port 0 read, addr 0x100, burst 4; PHY returns 0xA0..0xA3 -> port 0 sees 4 rx beats in order; port 1 sees none; busy_o falls after beat 4; trans_ready_o[0] pulses once.
- Ports 0 and 1 both request continuously with burst 2 -> grants alternate 0,1,0,1; trans_valid_o rises 1 cycle after IDLE detects the request.
- Port 1 write, burst 3, tx_valid gapped (1,0,1,1) -> PHY receives data 0x1111/0x2222/0x3333 with strobes unchanged; DATA holds until the 3rd handshake.
- Register write (space=1, write=1, burst 8) -> exactly 1 tx beat forwarded, then IDLE.
- Port 0 burst 0 -> err_o and req_trans_ready_o[0] pulse the same cycle; trans_valid_o stays 0; the next port 1 request is granted normally.
- rst_i asserted during DATA of a read -> next cycle busy_o=0, all valids 0, rr pointer 0.
